// File: rtl/skid_buffer_if.sv
// Handshake bundle between an upstream producer, the skid buffer and the
// downstream inverter stage.
interface skid_buffer_if #(
    parameter int N_BITS = 8
);
    // A word transfers on a rising clk edge exactly when its valid and ready are
    // both 1; valid may rise at any time, and data must hold until the transfer.
    logic [N_BITS-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: head register drives out_data, skid register absorbs a
// second word so in_ready/out_valid come purely from registered state.
module skid_buffer #(
    parameter int N_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    skid_buffer_if.slave       bus,
    output logic [1:0]         count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_BITS-1:0] head_q, head_d;
    logic [N_BITS-1:0] skid_q, skid_d;
    logic              push;
    logic              pop;

    // The state value is the occupancy, so count doubles as the FSM debug view.
    assign count         = state_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_data  = head_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = bus.in_data;
                    state_d = HALF;
                end
            end
            HALF: begin
                // A pop alone leaves head stale; out_valid already masks it.
                if (push && pop) begin
                    head_d = bus.in_data;
                end else if (push) begin
                    skid_d  = bus.in_data;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = HALF;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end
endmodule

// File: tb/tb_skid_buffer.sv
// Directed and random bench for skid_buffer with an expected-word queue
// filled by the driver and drained by an independent output monitor.
module tb_skid_buffer;
    logic       clk;
    logic       reset;
    logic [1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;

    skid_buffer_if #(.N_BITS(8)) bus ();

    skid_buffer #(.N_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: called at posedge+1; applies inputs for the next edge, records an
    // accepted push, and returns at posedge+1 after that edge.
    task automatic drive(input logic [7:0] d, input logic v, input logic r);
        bus.in_data   = d;
        bus.in_valid  = v;
        bus.out_ready = r;
        @(negedge clk);
        #1;
        if (v && bus.in_ready) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges while inputs stay as they are, checks the
    // asynchronous clear, and leaves reset low at posedge+1.
    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check({tag, "_count"},     32'(count),         32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"},  32'(bus.out_data),  32'h00);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // Monitor: at each negedge, with inputs settled for the coming edge.
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            check("count_range", 32'(count <= 2'd2), 32'd1);
            check("out_valid_decode", 32'(bus.out_valid), 32'(count != 2'd0));
            check("in_ready_decode", 32'(bus.in_ready), 32'(count != 2'd2));
            check("occupancy", 32'(count), 32'(exp_q.size()));
            if (stall_prev) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(stall_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_order: got %0h expected no word at %0t", bus.out_data, $time);
                end else begin
                    check("pop_order", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
        end
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("por_count",     32'(count),         32'd0);
        check("por_out_valid", 32'(bus.out_valid), 32'd0);
        check("por_out_data",  32'(bus.out_data),  32'h00);
        check("por_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;

        // First edge after release accepts a push
        reset = 1'b1;
        drive(8'h5A, 1'b1, 1'b0);
        check("first_push_count", 32'(count), 32'd1);
        check("first_push_data", 32'(bus.out_data), 32'h5A);
        check("first_push_valid", 32'(bus.out_valid), 32'd1);
        drive(8'h00, 1'b0, 1'b1);
        check("first_drain_count", 32'(count), 32'd0);

        // Fill then drain
        drive(8'hA5, 1'b1, 1'b0);
        drive(8'h3C, 1'b1, 1'b0);
        check("fill_count", 32'(count), 32'd2);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check("fill_head", 32'(bus.out_data), 32'hA5);

        // Full backpressure
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, 1'b1, 1'b0);
            check("bp_count", 32'(count), 32'd2);
            check("bp_head", 32'(bus.out_data), 32'hA5);
        end
        drive(8'h00, 1'b0, 1'b1);
        check("drain1_head", 32'(bus.out_data), 32'h3C);
        check("drain1_count", 32'(count), 32'd1);
        drive(8'h00, 1'b0, 1'b1);
        check("drain2_count", 32'(count), 32'd0);

        // Simultaneous push and pop in HALF
        drive(8'h11, 1'b1, 1'b0);
        check("sim_pre_head", 32'(bus.out_data), 32'h11);
        drive(8'h22, 1'b1, 1'b1);
        check("sim_head", 32'(bus.out_data), 32'h22);
        check("sim_count", 32'(count), 32'd1);
        drive(8'h00, 1'b0, 1'b1);

        // Streaming, one word per cycle
        for (int i = 0; i < 16; i++) begin
            drive(8'(i), 1'b1, 1'b1);
            check("stream_count", 32'(count), 32'd1);
            check("stream_head", 32'(bus.out_data), 32'(i));
        end
        drive(8'h00, 1'b0, 1'b1);
        check("stream_end_count", 32'(count), 32'd0);

        // Reset while full discards both words
        drive(8'h77, 1'b1, 1'b0);
        drive(8'h88, 1'b1, 1'b0);
        check("prerst_count", 32'(count), 32'd2);
        apply_reset("midrst");
        reset = 1'b1;
        drive(8'h99, 1'b1, 1'b0);
        check("postrst_head", 32'(bus.out_data), 32'h99);
        check("postrst_count", 32'(count), 32'd1);
        drive(8'h00, 1'b0, 1'b1);
        check("postrst_drain", 32'(count), 32'd0);

        // Random stress
        for (int i = 0; i < 10000; i++) begin
            drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
